// File: rtl/keypad_decoder.sv
// keypad_decoder
// Decode end of the keypad scanner bitmap interface. Each scan frame is
// debounced: the bitmap is accepted only after DEBOUNCE_FRAMES identical
// frames. Newly pressed keys are collected in a pending bitmap. From there
// they drain, lowest index first, into a small key-code FIFO. A valid/ready
// handshake reads the FIFO.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to build the hold counter.
// A single held key is then re-queued after REPEAT_DELAY frames and every
// REPEAT_RATE frames after that. Without the macro the REPEAT_* parameters
// are ignored.
module keypad_decoder #(
  parameter int unsigned N_COLUMN        = 4,
  parameter int unsigned N_ROW           = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_COLUMN*N_ROW-1:0]         keys,
  input  logic                              keys_valid,
  output logic [$clog2(N_COLUMN*N_ROW)-1:0] key_code,
  output logic                              key_valid,
  input  logic                              key_ready,
  output logic [N_COLUMN*N_ROW-1:0]         pressed,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

  localparam int unsigned NK  = N_COLUMN * N_ROW;
  localparam int unsigned CW  = $clog2(NK);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [FCW-1:0] DB_TARGET = FCW'(DEBOUNCE_FRAMES);
  localparam logic [PW:0]    FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  // Reject parameter sets the logic below cannot honour.
  if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
    $error("keypad_decoder: DEBOUNCE_FRAMES must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_decoder: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_decoder: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic [NK-1:0]  candidate_q, candidate_d;
  logic [NK-1:0]  stable_q, stable_d;
  logic [NK-1:0]  pending_q, pending_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [NK-1:0]  new_press;
  logic [NK-1:0]  repeat_bits;
  logic [NK-1:0]  enq_bit;
  logic [CW-1:0]  enq_code;
  logic [CW-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           push, pop;

  // Frame debounce: count identical frames, accept the bitmap at the target count.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    candidate_d = candidate_q;
    frame_cnt_d = frame_cnt_q;
    stable_d    = stable_q;
    if (keys_valid) begin
      if (keys == candidate_q) begin
        if (frame_cnt_q != DB_TARGET) frame_cnt_d = frame_cnt_q + FCW'(1);
      end else begin
        candidate_d = keys;
        frame_cnt_d = FCW'(1);
      end
      if (frame_cnt_d == DB_TARGET) stable_d = keys;
    end
    new_press = stable_d & ~stable_q;
  end

  // Lowest-index pending key; this is the code written on a push.
  always_comb begin
    enq_code = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pending_q[i]) enq_code = CW'(i);
    end
  end

  // Pending bitmap and FIFO pointers; a full FIFO blocks the push even when popping.
  always_comb begin
    push      = (pending_q != '0) && (count_q != FIFO_FULL);
    pop       = key_valid && key_ready;
    enq_bit   = pending_q & (~pending_q + NK'(1));
    pending_d = (pending_q & ~(push ? enq_bit : '0)) | new_press | repeat_bits;
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HW   = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DELAY_T = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] RATE_T  = HW'(REPEAT_RATE);

  logic [HW-1:0] hold_q, hold_d;
  logic          repeating_q, repeating_d;
  logic          single_key;

  // Hold counter: first repeat after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  always_comb begin
    hold_d      = hold_q;
    repeating_d = repeating_q;
    repeat_bits = '0;
    single_key  = (stable_q != '0) && ((stable_q & (stable_q - NK'(1))) == '0);
    if (keys_valid) begin
      if ((stable_d != stable_q) || !single_key) begin
        hold_d      = '0;
        repeating_d = 1'b0;
      end else begin
        hold_d = hold_q + HW'(1);
        if (!repeating_q && hold_d == DELAY_T) begin
          repeat_bits = stable_q;
          repeating_d = 1'b1;
          hold_d      = '0;
        end else if (repeating_q && hold_d == RATE_T) begin
          repeat_bits = stable_q;
          hold_d      = '0;
        end
      end
    end
  end

  // Hold counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      repeating_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      repeating_q <= repeating_d;
    end
  end
`else
  assign repeat_bits = '0;
`endif

  // Debounce, pending and FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      candidate_q <= '0;
      frame_cnt_q <= '0;
      stable_q    <= '0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      candidate_q <= candidate_d;
      frame_cnt_q <= frame_cnt_d;
      stable_q    <= stable_d;
      pending_q   <= pending_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; key_code is gated by key_valid, so stale entries never reach the port.
    if (push) mem_q[wr_ptr_q] <= enq_code;
  end

  assign key_valid  = (count_q != '0);
  assign key_code   = key_valid ? mem_q[rd_ptr_q] : '0;
  assign pressed    = stable_q;
  assign fifo_count = count_q;

endmodule
